// File: rtl/chronos_pkg.sv
// Shared types and constants for the Chronos RV32I front-end.
package chronos_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned INST_BYTES = 4;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2,
    ST_TRAP = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Shift-register FIFO of {pc, inst} pairs; head is always slot 0 and
// keeps its last value once the buffer drains.
module fetch_buf
  import chronos_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  fetch_entry_t     i_din,
  output logic [CNT_W-1:0] o_count,
  output fetch_entry_t     o_head
);

  fetch_entry_t     r_mem [DEPTH];
  fetch_entry_t     w_mem_nxt [DEPTH];
  logic [CNT_W-1:0] r_count;

  // Next storage contents: pop shifts toward slot 0, push fills the first free slot.
  always_comb begin
    w_mem_nxt = r_mem;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (i_pop) begin
        if (i_push && (CNT_W'(i + 1) == r_count)) begin
          w_mem_nxt[i] = i_din;
        end else if (CNT_W'(i + 1) < r_count) begin
          w_mem_nxt[i] = r_mem[(i < int'(DEPTH) - 1) ? i + 1 : i];
        end
      end else if (i_push && (CNT_W'(i) == r_count)) begin
        w_mem_nxt[i] = i_din;
      end
    end
  end

  // Storage and occupancy; flush empties the buffer but leaves the head visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_count <= '0;
    end else begin
      r_mem <= w_mem_nxt;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[0];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front-end: owns the PC, requests instruction words,
// buffers them and hands them to decode; handles redirects and halt.
module fetch_stage
  import chronos_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] fetch_addr,
  output logic        fetch_req,
  input  logic [31:0] request_data,
  input  logic        fetch_data_valid,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        misalign
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

  fetch_state_e     r_state;
  logic [XLEN-1:0]  r_pc;
  logic             r_misalign;

  logic [CNT_W-1:0] w_count;
  fetch_entry_t     w_head;
  fetch_entry_t     w_din;
  logic             w_push;
  logic             w_pop;
  logic             w_inst_valid;

  // Request only while running with buffer space; a redirect kills it in-cycle.
  assign fetch_req    = (r_state == ST_RUN) && (w_count < CNT_W'(BUF_DEPTH)) && !redirect_valid;
  assign w_push       = fetch_req && fetch_data_valid;
  assign w_inst_valid = (w_count != '0);
  assign w_pop        = w_inst_valid && inst_ready;
  assign w_din        = '{pc: r_pc, inst: request_data};

  fetch_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_din   (w_din),
    .o_count (w_count),
    .o_head  (w_head)
  );

  // Fetch control FSM with PC and sticky misalign flag; redirect overrides everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_PC;
      r_misalign <= 1'b0;
    end else if (redirect_valid) begin
      r_pc <= redirect_pc;
      if (redirect_pc[1:0] != 2'b00) begin
        r_misalign <= 1'b1;
        r_state    <= ST_TRAP;
      end else begin
        r_misalign <= 1'b0;
        r_state    <= halt ? ST_HALT : ST_RUN;
      end
    end else begin
      if (w_push) begin
        r_pc <= r_pc + XLEN'(INST_BYTES);
      end
      case (r_state)
        ST_IDLE: r_state <= halt ? ST_HALT : ST_RUN;
        ST_RUN:  if (halt) r_state <= ST_HALT;
        ST_HALT: if (!halt) r_state <= ST_RUN;
        ST_TRAP: r_state <= ST_TRAP;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign fetch_addr = r_pc;
  assign inst_valid = w_inst_valid;
  assign inst_data  = w_head.inst;
  assign inst_pc    = w_head.pc;
  assign misalign   = r_misalign;

endmodule
